// File: rtl/controller_fsm.sv
// Instruction-sequencing controller: captures an instruction word on start,
// decodes it and drives Moore control strobes for a register-file/ALU datapath.
module controller_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic        err,
  output logic [15:0] datapath_in,
  output logic        vsel,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  shift,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  ALUop
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_movi, is_mov, is_alu, is_cmp, uses_a, unary, is_defined;
  logic [1:0] alu_op_sel;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};

  assign is_movi    = (opcode == OPC_MOV) && (op == 2'b10);
  assign is_mov     = (opcode == OPC_MOV) && (op == 2'b00);
  assign is_alu     = (opcode == OPC_ALU);
  assign is_cmp     = is_alu && (op == 2'b01);
  // MVN is the only 101-class operation without an Rn operand.
  assign uses_a     = is_alu && (op != 2'b11);
  assign unary      = is_mov || (is_alu && (op == 2'b11));
  assign is_defined = is_movi || uses_a || unary;
  assign alu_op_sel = is_alu ? op : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          ir_d    = in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_movi)     state_d = S_WRITE_IMM;
        else if (uses_a) state_d = S_GET_A;
        else if (unary)  state_d = S_GET_B;
        else             state_d = S_WAIT;
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    err      = 1'b0;
    vsel     = 1'b0;
    writenum = 3'd0;
    readnum  = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    shift    = 2'b00;
    asel     = 1'b0;
    bsel     = 1'b0;
    ALUop    = 2'b00;
    case (state_q)
      S_WAIT:   w   = 1'b1;
      S_DECODE: err = ~is_defined;
      S_WRITE_IMM: begin
        write    = 1'b1;
        vsel     = 1'b1;
        writenum = rn;
      end
      S_GET_A: begin
        loada   = 1'b1;
        readnum = rn;
        shift   = sh;
        ALUop   = alu_op_sel;
      end
      S_GET_B: begin
        loadb   = 1'b1;
        readnum = rm;
        shift   = sh;
        ALUop   = alu_op_sel;
      end
      S_ALU: begin
        loadc = 1'b1;
        loads = is_alu;
        asel  = unary;
        shift = sh;
        ALUop = alu_op_sel;
      end
      S_WRITE_REG: begin
        write    = 1'b1;
        writenum = rd;
        shift    = sh;
        ALUop    = alu_op_sel;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller_fsm.sv
// Bench for controller_fsm driving a small behavioural register-file/ALU datapath;
// per-instruction strobe/latency expectations are checked through a scoreboard queue.
module tb_controller_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] in_w;
  logic        w, err, vsel, write, loada, loadb, loadc, loads, asel, bsel;
  logic [15:0] datapath_in;
  logic [2:0]  writenum, readnum;
  logic [1:0]  shift, ALUop;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {w-low cycles[4], err[2], write[2], loada[2], loadb[2], loadc[2], loads[2]}
  logic [15:0] exp_q[$];
  localparam logic [15:0] EXP_MOVI  = {4'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [15:0] EXP_ADD   = {4'd5, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
  localparam logic [15:0] EXP_CMP   = {4'd4, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
  localparam logic [15:0] EXP_MOV   = {4'd4, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
  localparam logic [15:0] EXP_MVN   = {4'd4, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
  localparam logic [15:0] EXP_UNDEF = {4'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

  controller_fsm dut (
    .clk(clk), .reset(reset), .s(s), .in(in_w),
    .w(w), .err(err), .datapath_in(datapath_in), .vsel(vsel),
    .writenum(writenum), .readnum(readnum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .shift(shift), .asel(asel), .bsel(bsel), .ALUop(ALUop)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural datapath ----------------
  logic [15:0] r_m [8];
  logic [15:0] a_m, b_m, c_m, sh_b, ain, bin, alu_y;
  logic        z_m;

  always @* begin
    case (shift)
      2'b00:   sh_b = b_m;
      2'b01:   sh_b = {b_m[14:0], 1'b0};
      2'b10:   sh_b = {1'b0, b_m[15:1]};
      default: sh_b = {b_m[15], b_m[15:1]};
    endcase
    ain = asel ? 16'd0 : a_m;
    bin = bsel ? datapath_in : sh_b;
    case (ALUop)
      2'b00:   alu_y = ain + bin;
      2'b01:   alu_y = ain - bin;
      2'b10:   alu_y = ain & bin;
      default: alu_y = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (write) r_m[writenum] <= vsel ? datapath_in : c_m;
    if (loada) a_m <= r_m[readnum];
    if (loadb) b_m <= r_m[readnum];
    if (loadc) c_m <= alu_y;
    if (loads) z_m <= (alu_y == 16'd0);
  end

  // ---------------- helpers ----------------
  function automatic logic [35:0] all_outs();
    return {w, err, datapath_in, vsel, writenum, readnum, write, loada, loadb,
            loadc, loads, shift, asel, bsel, ALUop};
  endfunction

  function automatic logic [18:0] idle_outs();
    return {err, vsel, writenum, readnum, write, loada, loadb, loadc, loads,
            shift, asel, bsel, ALUop};
  endfunction

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!w && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle", 48'(w), 48'(1'b1));
  endtask

  task automatic start_instr(input logic [15:0] instr);
    s    = 1'b1;
    in_w = instr;
    @(posedge clk); #1;
    s    = 1'b0;
  endtask

  task automatic run(input logic [15:0] instr, input logic [15:0] exp);
    exp_q.push_back(exp);
    start_instr(instr);
    wait_idle(20);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       busy = 1'b0;
  logic [3:0] low_c = '0;
  logic [1:0] err_c = '0, wr_c = '0, la_c = '0, lb_c = '0, lc_c = '0, ls_c = '0;
  logic [15:0] exp_e, got_e;

  always @(negedge clk) begin
    if (reset) begin
      busy = 1'b0;
      {low_c, err_c, wr_c, la_c, lb_c, lc_c, ls_c} = '0;
    end else if (!w) begin
      busy  = 1'b1;
      low_c = low_c + 4'd1;
      err_c = err_c + 2'(err);
      wr_c  = wr_c + 2'(write);
      la_c  = la_c + 2'(loada);
      lb_c  = lb_c + 2'(loadb);
      lc_c  = lc_c + 2'(loadc);
      ls_c  = ls_c + 2'(loads);
    end else begin
      chk("idle_outputs", 48'(idle_outs()), 48'(19'd0));
      if (busy) begin
        got_e = {low_c, err_c, wr_c, la_c, lb_c, lc_c, ls_c};
        if (exp_q.size() == 0) begin
          chk("scoreboard_unexpected", 48'(got_e), 48'hFFFF_FFFF_FFFF);
        end else begin
          exp_e = exp_q.pop_front();
          chk("scoreboard", 48'(got_e), 48'(exp_e));
        end
        busy = 1'b0;
        {low_c, err_c, wr_c, la_c, lb_c, lc_c, ls_c} = '0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 8; i++) r_m[i] = 16'd0;
    a_m = '0; b_m = '0; c_m = '0; z_m = 1'b0;
    reset = 1'b1;
    s     = 1'b0;
    in_w  = 16'd0;
    #1;
    chk("reset_outputs", 48'(all_outs()), 48'({1'b1, 35'd0}));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // MOVI R0,7 ; MOVI R1,2 ; ADD R2,R1,R0 LSL 1 -- first start right after reset release
    run(16'hD007, EXP_MOVI);
    run(16'hD102, EXP_MOVI);
    run(16'hA148, EXP_ADD);
    chk("add_r2", 48'(r_m[2]), 48'(16'd16));

    // MOVI R3,#-3: sign-extended immediate visible in WRITE_IMM
    exp_q.push_back(EXP_MOVI);
    start_instr(16'hD3FD);
    @(posedge clk); #1;
    chk("movi_write_imm", 48'({write, vsel, writenum, datapath_in}),
        48'({1'b1, 1'b1, 3'd3, 16'hFFFD}));
    wait_idle(20);
    chk("movi_r3", 48'(r_m[3]), 48'(16'hFFFD));

    // R1=7 then CMP R1,R0 -> zero, no register write
    run(16'hD107, EXP_MOVI);
    run(16'hA900, EXP_CMP);
    chk("cmp_z", 48'(z_m), 48'(1'b1));
    chk("cmp_r2_untouched", 48'(r_m[2]), 48'(16'd16));

    // AND R4,R3,R0 and MVN R5,R0
    run(16'hB380, EXP_ADD);
    chk("and_r4", 48'(r_m[4]), 48'(16'h0005));
    run(16'hB8A0, EXP_MVN);
    chk("mvn_r5", 48'(r_m[5]), 48'(16'hFFF8));

    // Undefined opcode 111
    run(16'hE000, EXP_UNDEF);

    // Abort ADD in ALU state with reset
    start_instr(16'hA148);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_in_alu", 48'({loadc, loads}), 48'(2'b11));
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", 48'(all_outs()), 48'({1'b1, 35'd0}));
    @(posedge clk); #1;
    reset = 1'b0;
    run(16'hD605, EXP_MOVI);
    chk("abort_r2_unchanged", 48'(r_m[2]), 48'(16'd16));
    chk("post_reset_movi_r6", 48'(r_m[6]), 48'(16'd5));

    // Back-to-back with s held: MOVI R0,7 then MOV R2,R0
    exp_q.push_back(EXP_MOVI);
    exp_q.push_back(EXP_MOV);
    s    = 1'b1;
    in_w = 16'hD007;
    @(posedge clk); #1;
    in_w = 16'hC040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_wait_one_cycle", 48'(w), 48'(1'b1));
    @(posedge clk); #1;
    chk("b2b_capture", 48'(w), 48'(1'b0));
    s = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("mov_alu_asel", 48'({loadc, asel, loads}), 48'(3'b110));
    wait_idle(20);
    chk("mov_r2", 48'(r_m[2]), 48'(16'd7));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 48'(exp_q.size()), 48'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller_fsm.md
CONTROLLER_FSM -- requirements
Module: controller_fsm

Interface
REQ-001 Port list, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state changes on rising edge
  reset  in  1  asynchronous, active-high; forces WAIT state and output defaults
  s  in  1  start; sampled only in WAIT
  in  in  16  instruction word; captured into instruction register (IR) on start
  w  out  1  idle flag; 1 only in WAIT
  err  out  1  undefined-instruction flag; 1 for the DECODE cycle of an undefined instruction
  datapath_in  out  16  sign-extended IR[7:0] (sximm8), driven continuously from IR
  vsel  out  1  1 = write datapath_in, 0 = write C
  writenum, readnum  out  3  register-file write and read selects
  write, loada, loadb, loadc, loads  out  1  datapath strobes
  shift  out  2  shifter control
  asel, bsel  out  1  ALU operand selects
  ALUop  out  2  ALU operation
REQ-002 Clock port is clk; reset port is reset, asynchronous and active-high.

Function
REQ-003 IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], imm8=IR[7:0].
REQ-004 Decoded instructions (all other opcode/op pairs are undefined):
  MOVI (110/10): Rn = sximm8
  MOV (110/00): Rd = sh(Rm)
  ADD (101/00): Rd = Rn + sh(Rm)
  CMP (101/01): status = Rn - sh(Rm)
  AND (101/10): Rd = Rn & sh(Rm)
  MVN (101/11): Rd = ~sh(Rm)
REQ-005 States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
REQ-006 WAIT with s=1: capture in into IR and go to DECODE. WAIT with s=0: stay in WAIT. In all states other than WAIT, s and in are ignored.
REQ-007 Transitions out of DECODE:
  MOVI -> WRITE_IMM
  ADD/CMP/AND -> GET_A
  MOV/MVN -> GET_B
  undefined -> WAIT with err=1
REQ-008 Other transitions:
  WRITE_IMM -> WAIT
  GET_A -> GET_B
  GET_B -> ALU
  ALU -> WAIT for CMP, otherwise -> WRITE_REG
  WRITE_REG -> WAIT
REQ-009 Moore outputs per state (any output not listed is 0):
  WRITE_IMM: write=1, vsel=1, writenum=Rn
  GET_A: loada=1, readnum=Rn
  GET_B: loadb=1, readnum=Rm
  ALU: loadc=1, loads=1 only for opcode 101, asel=1 for MOV/MVN
  WRITE_REG: write=1, vsel=0, writenum=Rd
REQ-010 Outside WAIT, DECODE and WRITE_IMM: shift=sh, and ALUop=op for opcode 101 or 00 (ADD) for MOV. bsel=0 always.
REQ-011 In WAIT, DECODE and WRITE_IMM: shift=00 and ALUop=00.
REQ-012 Cycles with w=0 after the start edge: MOVI 2; MOV/MVN 4; CMP 4; ADD/AND 5; undefined 1.
REQ-013 With s held high, a new instruction is captured on the first clock edge after w returns to 1; there are no dead cycles beyond that.
REQ-014 Each strobe is asserted for exactly one cycle per instruction. No strobe is ever asserted in WAIT.

Reset
REQ-015 When reset=1, without waiting for a clock edge: state=WAIT, IR=0, w=1, err=0, all strobes 0, all selects/shift/ALUop 0, datapath_in=0.
REQ-016 Reset asserted mid-instruction aborts that instruction; no further strobe of that instruction occurs after reset is released.
REQ-017 The first s is honoured on the first rising edge after reset deasserts.

Verification (bench pairs controller_fsm with datapath)
REQ-018 After reset, issue 0xD007, then 0xD102, then 0xA148. Required: R2=16, and w is low for 2, 2 and 5 cycles respectively.
REQ-019 Issue 0xD3FD. Required: datapath_in=0xFFFD in WRITE_IMM, R3=0xFFFD.
REQ-020 Preload R0=7 and R1=7, then issue CMP R1,R0 (0xA900). Required: loads pulses once, Z_out=1, no write strobe, w low for 4 cycles.
REQ-021 Issue 0xE000 (undefined). Required: err=1 for one cycle, no strobes, w=1 on the following cycle.
REQ-022 Assert reset in the ALU state of 0xA148. Required: outputs return to defaults immediately, R2 is unchanged, and the next MOVI completes normally.
REQ-023 Hold s=1 while issuing 0xD007 then 0xC040 (MOV R2,R0). Required: back-to-back capture, asel=1 in ALU, R2=7.
